// File: rtl/nibble_demux.sv
// nibble_demux: steers input nibbles into four lane holding registers, each drained by its own valid/ready handshake.
// Define NIBBLE_DEMUX_AUTO_EN to build in the a->b->c->d auto-mode sequencer and its frame_done pulse.
module nibble_demux (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] din,
    input  logic       s1,
    input  logic       s2,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       auto_mode,
    output logic [3:0] out_a,
    output logic [3:0] out_b,
    output logic [3:0] out_c,
    output logic [3:0] out_d,
    output logic [3:0] lane_valid,
    input  logic [3:0] lane_ready,
    output logic       frame_done
);
    // Lane bit index equals {s1,s2}: 3=a, 2=b, 1=c, 0=d; data nibble i lives at data_q[4*i+:4].
    logic [15:0] data_q, data_d;
    logic [3:0]  valid_q, valid_d, wr;
    logic [1:0]  sel;
    logic        accept;
`ifdef NIBBLE_DEMUX_AUTO_EN
    logic [1:0] ptr_q, ptr_d;
    logic       frame_q, frame_d;
    // Pointer A..D counts up while lanes a..d count down, so the lane bit is the inverted pointer.
    assign sel        = auto_mode ? ~ptr_q : {s1, s2};
    assign frame_done = frame_q;
    always_comb begin
        ptr_d   = !auto_mode ? 2'd0 : (accept ? ptr_q + 2'd1 : ptr_q);
        frame_d = auto_mode & accept & (ptr_q == 2'd3);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= 2'd0;
            frame_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            frame_q <= frame_d;
        end
    end
`else
    logic unused_auto_mode;
    assign unused_auto_mode = auto_mode;
    assign sel              = {s1, s2};
    assign frame_done       = 1'b0;
`endif
    assign in_ready   = ~valid_q[sel] | lane_ready[sel];
    assign accept     = in_valid & in_ready;
    assign lane_valid = valid_q;
    assign out_a      = data_q[15:12];
    assign out_b      = data_q[11:8];
    assign out_c      = data_q[7:4];
    assign out_d      = data_q[3:0];
    always_comb begin
        wr      = accept ? 4'b0001 << sel : 4'b0000;
        valid_d = (valid_q & ~lane_ready) | wr;
        data_d  = data_q;
        for (int i = 0; i < 4; i++)
            if (wr[i]) data_d[4*i+:4] = din;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= 16'h0000;
            valid_q <= 4'b0000;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: doc/nibble_demux.md
NIBBLE_DEMUX -- requirements
Module: nibble_demux

Interface
REQ-001 SHALL have no parameters; all widths are fixed (4-bit nibbles, 4 lanes).
REQ-002 SHALL provide ports, clock and reset first:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  4  input nibble.
- s1  input  1  lane select bit.
- s2  input  1  lane select bit.
- in_valid  input  1  din/s1/s2 valid.
- in_ready  output  1  block can accept din this cycle.
- auto_mode  input  1  1 = internal sequencer selects the lane; s1/s2 are ignored.
- out_a, out_b, out_c, out_d  output  4 each  lane holding registers.
- lane_valid  output  4  bit3=a, bit2=b, bit1=c, bit0=d; lane register holds unread data.
- lane_ready  input  4  same bit order; downstream consumes the lane.
- frame_done  output  1  one-cycle pulse when an auto-mode frame completes.
REQ-003 SHALL have one clock (clk); reset is asynchronous and active-low (rst_n).

Function
REQ-004 Manual-mode lane decode SHALL be: s1&s2 -> a; s2 only -> c; s1 only -> b; neither -> d.
REQ-005 Transfer on a lane SHALL occur when lane_valid[i] & lane_ready[i] at a rising edge.
REQ-006 in_ready SHALL equal (~lane_valid[sel] | lane_ready[sel]) for the selected lane; it is combinational from s1, s2, the auto pointer, lane_valid and lane_ready.
REQ-007 An accept SHALL occur when in_valid & in_ready; din is written to the selected lane register and lane_valid[sel] is set at that edge (1-cycle latency).
REQ-008 A lane that is drained and rewritten in the same cycle SHALL stay valid and hold the new nibble, with no bubble.
REQ-009 A lane drained without rewrite SHALL clear lane_valid; its out_x SHALL hold the last value.
REQ-010 Non-selected lanes SHALL be unaffected by an accept; the four lanes drain independently and concurrently.
REQ-011 in_valid while in_ready=0 SHALL write nothing; the producer holds din/s1/s2 stable until accepted.
REQ-012 Auto mode SHALL use a 2-bit pointer with states A(0)->B(1)->C(2)->D(3)->A that advances only on an accept.
REQ-013 frame_done SHALL pulse high for one cycle, the cycle after the accept in state D.
REQ-014 auto_mode low SHALL force the pointer to A synchronously; a partial frame is abandoned and already-written lanes keep their data.
REQ-015 lane_ready bits for lanes with lane_valid=0 SHALL be ignored.

Reset
REQ-016 rst_n low SHALL immediately clear out_a..out_d to 4'h0, lane_valid to 4'b0000, the pointer to A, and frame_done to 0.
REQ-017 in_ready SHALL be 1 during and after reset, because all lanes are empty.
REQ-018 Reset mid-frame SHALL discard all held nibbles; the first accept after release in auto mode SHALL go to lane a.

Configuration
REQ-019 Macro NIBBLE_DEMUX_AUTO_EN defined SHALL compile in the auto-mode sequencer (REQ-012..014).
REQ-020 Without NIBBLE_DEMUX_AUTO_EN, the auto_mode port SHALL remain present but be ignored, selection SHALL always be manual, and frame_done SHALL be tied 0.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Manual mode, lane_ready=4'b0000: send din=5,6,7,8 with (s1,s2)=(1,1),(1,0),(0,1),(0,0) -> out_a=5, out_b=6, out_c=7, out_d=8, lane_valid=4'b1111.
- Lane a full, lane_ready[3]=0: send s1=s2=1 din=9 -> in_ready=0, out_a unchanged; then raise lane_ready[3] -> same-edge accept, out_a=9, lane_valid[3] stays 1.
- Auto mode (macro defined), lane_ready=4'b1111: stream 1,2,3,4,5 -> a=1, b=2, c=3, d=4, frame_done one pulse, then a=5.
- Auto mode, after 2 accepts drop auto_mode for 1 cycle, re-enter and send din=E -> out_a=E, frame_done not pulsed.
- Assert rst_n low mid-frame with lanes full -> all outputs 0, lane_valid=0, in_ready=1 before the next clk edge.
- Macro undefined: auto_mode=1, s1=0, s2=1, din=3 -> out_c=3, frame_done remains 0.
